// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with first-word-fall-through receive FIFO
module uart_rx_param #(
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1,
   parameter int DIV_WIDTH  = 24,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                         uart_clock,
   input  logic                         uart_reset,
   input  logic                         uart_d_in,
   input  logic [DIV_WIDTH-1:0]         baud_div,
   output logic [DATA_BITS-1:0]         rx_data,
   output logic                         rx_frame_err,
   output logic                         rx_parity_err,
   output logic                         rx_valid,
   input  logic                         rx_ready,
   output logic                         overrun_err,
   input  logic                         err_clear,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int WW = DATA_BITS + 2;
   localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);
   localparam logic [DIV_WIDTH-1:0] MIN_DIV = DIV_WIDTH'(4);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   logic                 sync1, rxs, rxs_d;
   state_t               state, state_n;
   logic [DIV_WIDTH-1:0] cnt, cnt_n, div, div_n, half, half_n;
   logic [DATA_BITS-1:0] shift, shift_n;
   logic [3:0]           bcnt, bcnt_n;
   logic                 perr, perr_n, ferr, ferr_n, wr_en;
   logic [WW-1:0]        wr_word;
   logic [WW-1:0]        mem [FIFO_DEPTH];
   logic [AW-1:0]        wptr, rptr;
   logic                 full, pop, push;

   always_ff @(posedge uart_clock or posedge uart_reset) begin
      if (uart_reset) begin
         sync1 <= 1'b1;
         rxs   <= 1'b1;
         rxs_d <= 1'b1;
      end else begin
         sync1 <= uart_d_in;
         rxs   <= sync1;
         rxs_d <= rxs;
      end
   end

   always_ff @(posedge uart_clock or posedge uart_reset) begin
      if (uart_reset) begin
         state <= IDLE;
         cnt   <= '0;
         div   <= MIN_DIV;
         half  <= '0;
         shift <= '0;
         bcnt  <= '0;
         perr  <= 1'b0;
         ferr  <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         div   <= div_n;
         half  <= half_n;
         shift <= shift_n;
         bcnt  <= bcnt_n;
         perr  <= perr_n;
         ferr  <= ferr_n;
      end
   end

   // All bit samples land when cnt reaches its terminal value; the counter restarts on each sample.
   always_comb begin
      state_n = state;
      cnt_n   = cnt + ONE;
      div_n   = div;
      half_n  = half;
      shift_n = shift;
      bcnt_n  = bcnt;
      perr_n  = perr;
      ferr_n  = ferr;
      wr_en   = 1'b0;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (rxs_d && !rxs) begin
               div_n   = (baud_div < MIN_DIV) ? MIN_DIV : baud_div;
               half_n  = div_n >> 1;
               bcnt_n  = '0;
               perr_n  = 1'b0;
               ferr_n  = 1'b0;
               state_n = START;
            end
         end
         START: begin
            if (cnt == half - ONE) begin
               cnt_n   = '0;
               state_n = rxs ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt == div - ONE) begin
               cnt_n   = '0;
               shift_n = {rxs, shift[DATA_BITS-1:1]};
               bcnt_n  = bcnt + 4'd1;
               if (bcnt == 4'(DATA_BITS - 1)) begin
                  bcnt_n  = '0;
                  state_n = (PARITY_EN != 0) ? PARITY : STOP;
               end
            end
         end
         PARITY: begin
            if (cnt == div - ONE) begin
               cnt_n   = '0;
               perr_n  = (^shift) ^ rxs ^ 1'(PARITY_ODD);
               state_n = STOP;
            end
         end
         STOP: begin
            if (cnt == div - ONE) begin
               cnt_n  = '0;
               ferr_n = ferr | ~rxs;
               bcnt_n = bcnt + 4'd1;
               if (bcnt == 4'(STOP_BITS - 1)) begin
                  wr_en   = 1'b1;
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign wr_word = {perr, ferr_n, shift};

   assign rx_valid = (fifo_count != '0);
   assign full     = (fifo_count == (AW+1)'(FIFO_DEPTH));
   assign pop      = rx_valid & rx_ready;
   assign push     = wr_en & (~full | pop);

   always_ff @(posedge uart_clock) begin
      if (push) mem[wptr] <= wr_word;
   end

   always_ff @(posedge uart_clock or posedge uart_reset) begin
      if (uart_reset) begin
         wptr        <= '0;
         rptr        <= '0;
         fifo_count  <= '0;
         overrun_err <= 1'b0;
      end else begin
         if (push) wptr <= wptr + AW'(1);
         if (pop)  rptr <= rptr + AW'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
            2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
            default: fifo_count <= fifo_count;
         endcase
         // A drop in the same cycle as err_clear must remain visible.
         if (wr_en && full && !pop) overrun_err <= 1'b1;
         else if (err_clear)        overrun_err <= 1'b0;
      end
   end

   // Outputs read zero while empty so the head fields never expose stale storage.
   assign {rx_parity_err, rx_frame_err, rx_data} = rx_valid ? mem[rptr] : '0;
endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - self-checking bench for uart_rx_param (8N1 and 8E2 instances)
module tb_uart_rx_param;
   typedef struct packed {
      logic [7:0] d;
      logic       fe;
      logic       pe;
   } word_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        d0, d1, r0, r1, err_clear;
   logic [23:0] baud_div;
   logic [7:0]  data0, data1;
   logic        fe0, fe1, pe0, pe1, v0, v1, ovr0, ovr1;
   logic [2:0]  cnt0, cnt1;

   word_t q0[$];
   word_t q1[$];
   logic  exp_ovr0, exp_ovr1;
   int    checks = 0;
   int    failures = 0;

   always #5 clk = ~clk;

   uart_rx_param dut0 (
      .uart_clock(clk), .uart_reset(rst), .uart_d_in(d0), .baud_div(baud_div),
      .rx_data(data0), .rx_frame_err(fe0), .rx_parity_err(pe0), .rx_valid(v0),
      .rx_ready(r0), .overrun_err(ovr0), .err_clear(err_clear), .fifo_count(cnt0)
   );

   uart_rx_param #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut1 (
      .uart_clock(clk), .uart_reset(rst), .uart_d_in(d1), .baud_div(baud_div),
      .rx_data(data1), .rx_frame_err(fe1), .rx_parity_err(pe1), .rx_valid(v1),
      .rx_ready(r1), .overrun_err(ovr1), .err_clear(err_clear), .fifo_count(cnt1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_bit(input int t, input logic b, input int div);
      if (t == 0) d0 = b;
      else        d1 = b;
      repeat (div) @(posedge clk);
      #1;
   endtask

   // Frame-level model: a word is pushed unless four are already waiting unread.
   task automatic send(input int t, input logic [7:0] data, input logic pbit,
                       input logic [1:0] stops, input int div);
      int    ed;
      int    nstop;
      int    ones;
      word_t w;
      ed = (div < 4) ? 4 : div;
      nstop = (t == 1) ? 2 : 1;
      baud_div = 24'(div);
      drive_bit(t, 1'b0, ed);
      for (int i = 0; i < 8; i++) drive_bit(t, data[i], ed);
      if (t == 1) drive_bit(t, pbit, ed);
      for (int i = 0; i < nstop; i++) drive_bit(t, stops[i], ed);
      ones = $countones(data) + int'(pbit);
      w.d  = data;
      w.fe = (nstop == 2) ? !(stops == 2'b11) : !stops[0];
      w.pe = (t == 1) ? ((ones % 2) != 0) : 1'b0;
      if (w.fe) drive_bit(t, 1'b1, ed);
      if (t == 0) begin
         if (q0.size() == 4) exp_ovr0 = 1'b1;
         else q0.push_back(w);
      end else begin
         if (q1.size() == 4) exp_ovr1 = 1'b1;
         else q1.push_back(w);
      end
   endtask

   task automatic drain(input int t, input string tag);
      word_t w;
      int    n;
      repeat (4) @(posedge clk);
      n = (t == 0) ? q0.size() : q1.size();
      check({tag, "_count"}, 32'((t == 0) ? cnt0 : cnt1), 32'(n));
      check({tag, "_ovr"}, 32'((t == 0) ? ovr0 : ovr1), 32'((t == 0) ? exp_ovr0 : exp_ovr1));
      for (int i = 0; i < n; i++) begin
         w = (t == 0) ? q0[0] : q1[0];
         if (t == 0) void'(q0.pop_front());
         else        void'(q1.pop_front());
         @(negedge clk);
         check({tag, "_valid"}, 32'((t == 0) ? v0 : v1), 32'd1);
         check({tag, "_data"}, 32'((t == 0) ? data0 : data1), 32'(w.d));
         check({tag, "_ferr"}, 32'((t == 0) ? fe0 : fe1), 32'(w.fe));
         check({tag, "_perr"}, 32'((t == 0) ? pe0 : pe1), 32'(w.pe));
         if (t == 0) r0 = 1'b1;
         else        r1 = 1'b1;
         @(posedge clk);
         #1;
         r0 = 1'b0;
         r1 = 1'b0;
      end
      @(negedge clk);
      check({tag, "_empty_valid"}, 32'((t == 0) ? v0 : v1), 32'd0);
      check({tag, "_empty_count"}, 32'((t == 0) ? cnt0 : cnt1), 32'd0);
   endtask

   initial begin
      int          bad;
      logic [7:0]  rd;
      int          rdiv;
      logic [1:0]  rst_bits;
      rst = 1'b1; d0 = 1'b1; d1 = 1'b1; r0 = 1'b0; r1 = 1'b0;
      err_clear = 1'b0; baud_div = 24'd8; exp_ovr0 = 1'b0; exp_ovr1 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_valid", 32'(v0), 32'd0);
      check("reset_data", 32'(data0), 32'd0);
      check("reset_flags", 32'({fe0, pe0, ovr0}), 32'd0);
      check("reset_count", 32'(cnt0), 32'd0);
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      send(0, 8'hA5, 1'b0, 2'b11, 8);
      drain(0, "basic");

      send(1, 8'h3C, 1'b1, 2'b11, 8);
      send(1, 8'h3C, 1'b0, 2'b11, 8);
      drain(1, "parity");

      send(0, 8'h55, 1'b0, 2'b00, 8);
      send(0, 8'h12, 1'b0, 2'b11, 8);
      drain(0, "frame");
      send(1, 8'h81, 1'b0, 2'b01, 8);
      drain(1, "stop2");

      baud_div = 24'd16;
      d0 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      d0 = 1'b1;
      bad = 0;
      repeat (60) begin
         @(negedge clk);
         if (v0 !== 1'b0) bad++;
      end
      check("glitch_valid_cycles", 32'(bad), 32'd0);
      check("glitch_count", 32'(cnt0), 32'd0);

      for (int v = 1; v <= 5; v++) send(0, 8'(v), 1'b0, 2'b11, 8);
      drain(0, "overrun");
      check("overrun_held", 32'(ovr0), 32'd1);
      err_clear = 1'b1;
      @(posedge clk);
      #1;
      err_clear = 1'b0;
      exp_ovr0 = 1'b0;
      @(negedge clk);
      check("overrun_cleared", 32'(ovr0), 32'd0);

      send(0, 8'h3A, 1'b0, 2'b11, 8);
      drive_bit(0, 1'b0, 8);
      rd = 8'h77;
      for (int i = 0; i < 3; i++) drive_bit(0, rd[i], 8);
      rst = 1'b1;
      #1;
      check("midreset_valid", 32'(v0), 32'd0);
      check("midreset_count", 32'(cnt0), 32'd0);
      check("midreset_data", 32'(data0), 32'd0);
      q0.delete();
      exp_ovr0 = 1'b0;
      d0 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      send(0, 8'h9C, 1'b0, 2'b11, 12);
      drain(0, "after_reset");

      for (int blk = 0; blk < 3; blk++) begin
         for (int i = 0; i < 3; i++) begin
            rd = 8'($urandom);
            rdiv = int'($urandom_range(20, 2));
            rst_bits = ($urandom_range(3, 0) == 0) ? 2'b10 : 2'b11;
            send(0, rd, 1'b0, rst_bits, rdiv);
         end
         drain(0, "rand0");
         for (int i = 0; i < 3; i++) begin
            rd = 8'($urandom);
            rdiv = int'($urandom_range(20, 2));
            rst_bits = ($urandom_range(3, 0) == 0) ? 2'($urandom_range(2, 0)) : 2'b11;
            send(1, rd, 1'($urandom), rst_bits, rdiv);
         end
         drain(1, "rand1");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
